// File: rtl/cd_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
// Optional build macro: BCD_CD_AUTORELOAD_EN (see bcd_mmss_countdown.sv).
package cd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t SEC_ONES_MAX = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
  localparam bcd_digit_t MIN_ONES_MAX = 4'd9;

  // Clamp a loaded digit to its legal maximum.
  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input bcd_digit_t max_val);
    return (d > max_val) ? max_val : d;
  endfunction

  // Wrap value of digit position idx (0 = seconds ones ... 3 = minutes tens).
  function automatic int digit_max(input int idx, input int min_tens_max);
    case (idx)
      0:       return int'(SEC_ONES_MAX);
      1:       return int'(SEC_TENS_MAX);
      2:       return int'(MIN_ONES_MAX);
      default: return min_tens_max;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit down-counter: wraps 0 -> MAX with a borrow, sync load wins.
module bcd_digit_dec
  import cd_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] q_o,
  output logic       borrow_o
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next digit value: load, decrement with wrap, or hold.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i) begin
      digit_d = (digit_q == 4'd0) ? 4'(MAX) : (digit_q - 4'd1);
    end
  end

  // Digit register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q_o      = digit_q;
  assign borrow_o = en_i & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_mmss_countdown.sv
// BCD MM:SS countdown timer with load/clear/start/pause control.
// Build macro BCD_CD_AUTORELOAD_EN: on reaching 00:00 reload the preset and
// keep running instead of stopping in the terminal DONE state.
module bcd_mmss_countdown
  import cd_pkg::*;
#(
  parameter int MIN_TENS_MAX = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  input  logic        clear,
  input  logic        start,
  input  logic        pause,
  input  logic        tick,
  output logic [15:0] qout,
  output logic        bout,
  output logic        running,
  output logic        done,
  output logic        expired
);

  state_t      state_q, state_d;
  logic [15:0] preset_q;
  logic        done_q, done_d;
  logic [15:0] data_san;
  logic        dig_load;
  logic [15:0] dig_load_val;
  logic        step_en;
  logic [4:0]  borrow;
  logic        final_step;

  assign data_san = {clamp_digit(data[15:12], 4'(MIN_TENS_MAX)),
                     clamp_digit(data[11:8],  MIN_ONES_MAX),
                     clamp_digit(data[7:4],   SEC_TENS_MAX),
                     clamp_digit(data[3:0],   SEC_ONES_MAX)};

  // The last tick counts 00:01 -> 00:00 by a load rather than a decrement.
  assign final_step = (qout == 16'h0001);

  // Command decode and FSM next state; load > clear > pause > start > tick.
  always_comb begin
    state_d      = state_q;
    dig_load     = 1'b0;
    dig_load_val = qout;
    step_en      = 1'b0;
    done_d       = 1'b0;
    if (load) begin
      dig_load     = 1'b1;
      dig_load_val = data_san;
      state_d      = ST_IDLE;
    end else if (clear) begin
      dig_load     = 1'b1;
      dig_load_val = preset_q;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef BCD_CD_AUTORELOAD_EN
          if (!pause && start && (qout != 16'h0000) && (preset_q != 16'h0000)) begin
`else
          if (!pause && start && (qout != 16'h0000)) begin
`endif
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (final_step) begin
              dig_load = 1'b1;
              done_d   = 1'b1;
`ifdef BCD_CD_AUTORELOAD_EN
              dig_load_val = preset_q;
              state_d      = ST_RUN;
`else
              dig_load_val = 16'h0000;
              state_d      = ST_DONE;
`endif
            end else begin
              step_en = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause && start) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, preset and done-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      preset_q <= 16'h0000;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load) begin
        preset_q <= data_san;
      end
    end
  end

  assign borrow[0] = step_en;

  // Four chained digits; each borrow enables the next more-significant digit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      bcd_digit_dec #(
        .MAX(digit_max(gi, MIN_TENS_MAX))
      ) u_digit (
        .clk       (clk),
        .reset     (reset),
        .load_i    (dig_load),
        .load_val_i(dig_load_val[gi*4 +: 4]),
        .en_i      (borrow[gi]),
        .q_o       (qout[gi*4 +: 4]),
        .borrow_o  (borrow[gi+1])
      );
    end
  endgenerate

  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_DONE);
  assign done    = done_q;
  assign bout    = running & tick & (qout[7:0] == 8'h00) & (borrow[4] | 1'b1);

endmodule

// File: tb/tb_bcd_mmss_countdown.sv
// Directed self-checking bench for bcd_mmss_countdown.
module tb_bcd_mmss_countdown;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data;
  logic        load, clear, start, pause, tick;
  logic [15:0] qout;
  logic        bout, running, done, expired;

  int checks = 0;
  int errors = 0;

  bcd_mmss_countdown #(.MIN_TENS_MAX(9)) dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .load   (load),
    .clear  (clear),
    .start  (start),
    .pause  (pause),
    .tick   (tick),
    .qout   (qout),
    .bout   (bout),
    .running(running),
    .done   (done),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v)
      $display("check %-14s observed=%h expected=%h ok", tag, obs, exp_v);
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; clear = 0; start = 0; pause = 0; tick = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    data = v; load = 1; cyc(); load = 0;
  endtask

  initial begin
    data = 16'h0000;
    idle_inputs();
    reset = 0;
    cyc(); cyc();
    chk("rst_qout", qout, 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_expired", {15'd0, expired}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    reset = 1;
    cyc();

    // Seconds borrow into minutes.
    do_load(16'h0103);
    chk("ld_0103", qout, 16'h0103);
    chk("ld_idle", {15'd0, running}, 16'd0);
    start = 1; cyc(); start = 0;
    chk("start_run", {15'd0, running}, 16'd1);
    tick = 1;
    #1 chk("bout_lo", {15'd0, bout}, 16'd0);
    cyc(); chk("t1_0102", qout, 16'h0102);
    cyc(); chk("t2_0101", qout, 16'h0101);
    cyc(); chk("t3_0100", qout, 16'h0100);
    #1 chk("bout_hi", {15'd0, bout}, 16'd1);
    cyc(); chk("t4_0059", qout, 16'h0059);
    tick = 0;

    // Final step to 00:00.
    do_load(16'h0002);
    start = 1; cyc(); start = 0;
    tick = 1;
    cyc(); chk("fin_0001", qout, 16'h0001);
    chk("fin_nodone", {15'd0, done}, 16'd0);
    cyc();
`ifdef BCD_CD_AUTORELOAD_EN
    chk("ar_reload", qout, 16'h0002);
    chk("ar_running", {15'd0, running}, 16'd1);
    chk("ar_done", {15'd0, done}, 16'd1);
    chk("ar_expired", {15'd0, expired}, 16'd0);
    tick = 0;
    cyc();
    chk("ar_done_off", {15'd0, done}, 16'd0);
    chk("ar_hold", qout, 16'h0002);
`else
    chk("fin_0000", qout, 16'h0000);
    chk("fin_expired", {15'd0, expired}, 16'd1);
    chk("fin_running", {15'd0, running}, 16'd0);
    chk("fin_done", {15'd0, done}, 16'd1);
    start = 1;
    cyc();
    chk("fin_done_off", {15'd0, done}, 16'd0);
    chk("fin_hold", qout, 16'h0000);
    cyc();
    chk("fin_exp_hold", {15'd0, expired}, 16'd1);
    chk("fin_hold2", qout, 16'h0000);
    start = 0; tick = 0;
`endif

    // Sanitization and zero-start.
    do_load(16'hAB7F);
    chk("sanitize", qout, 16'h9959);
    do_load(16'h0000);
    start = 1; cyc(); start = 0;
    chk("zero_start", {15'd0, running}, 16'd0);

    // Pause/start/clear/load priority.
    do_load(16'h0530);
    start = 1; cyc(); start = 0;
    chk("run_0530", {15'd0, running}, 16'd1);
    pause = 1; start = 1; tick = 1;
    cyc();
    pause = 0; start = 0; tick = 0;
    chk("pause_state", {15'd0, running}, 16'd0);
    chk("pause_hold", qout, 16'h0530);
    start = 1; cyc(); start = 0;
    chk("resume", {15'd0, running}, 16'd1);
    tick = 1; cyc(); tick = 0;
    chk("tick_0529", qout, 16'h0529);
    clear = 1; cyc(); clear = 0;
    chk("clear_val", qout, 16'h0530);
    chk("clear_idle", {15'd0, running}, 16'd0);
    data = 16'h0245; load = 1; clear = 1; tick = 1;
    cyc();
    idle_inputs();
    chk("load_wins", qout, 16'h0245);

    // Asynchronous reset mid-run.
    do_load(16'h1234);
    start = 1; cyc(); start = 0;
    chk("pre_rst_run", {15'd0, running}, 16'd1);
    #2 reset = 0;
    #1;
    chk("arst_qout", qout, 16'h0000);
    chk("arst_running", {15'd0, running}, 16'd0);
    chk("arst_expired", {15'd0, expired}, 16'd0);
    cyc();
    reset = 1;
    tick = 1;
    cyc(); cyc(); cyc();
    tick = 0;
    chk("post_rst_tick", qout, 16'h0000);
    chk("post_rst_idle", {15'd0, running}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_mmss_countdown.md
Name: bcd_mmss_countdown

Overview:
- BCD minutes:seconds countdown timer.
- Counts MM:SS down from a loaded preset, one step per qualified tick. Chains a borrow out in the opposite direction to the up-counting mod-60 carry chain.
- Sits in the timer/clock datapath next to the BCD up-counters; driven by a 1 Hz enable from the prescaler.
- Raises a done pulse and an expired flag at 00:00.

Parameters:
- MIN_TENS_MAX, 9, largest legal minutes-tens digit; loads above it clamp to it.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- data  input  16  BCD preset {min_tens, min_ones, sec_tens, sec_ones}
- load  input  1  load data as count and preset
- clear  input  1  restore count from stored preset
- start  input  1  begin/resume counting
- pause  input  1  suspend counting
- tick  input  1  count enable, 1-cycle pulse
- qout  output  16  current BCD count
- bout  output  1  minute borrow (combinational)
- running  output  1  high in RUN state
- done  output  1  registered 1-cycle pulse on reaching 00:00
- expired  output  1  high in DONE state

Behaviour:
- Reset, while reset=0:
  - qout=16'h0000, preset=16'h0000, state=IDLE.
  - done=0, running=0, expired=0.
  - Takes effect immediately, mid-count included.
- States: IDLE, RUN, PAUSE, DONE.
- Synchronous command priority per cycle: load > clear > pause > start > tick.
- load (any state):
  - Sanitize data: sec_ones/min_ones >9 -> 9; sec_tens >5 -> 5; min_tens >MIN_TENS_MAX -> MIN_TENS_MAX.
  - Sanitized value goes to qout and preset; state -> IDLE.
- clear (any state): qout<=preset, state -> IDLE.
- start:
  - IDLE -> RUN if qout!=0, else ignored.
  - PAUSE -> RUN.
  - Ignored in RUN and DONE.
- pause: RUN -> PAUSE; ignored elsewhere. If start and pause are both high, pause wins.
- RUN with tick=1: qout decrements by one second on that edge; zero added latency.
  - sec_ones 0 -> 9 with borrow, else -1.
  - sec_tens on borrow: 0 -> 5 with borrow, else -1.
  - min_ones on borrow: 0 -> 9 with borrow, else -1.
  - min_tens on borrow: -1; never underflows because 00:00 is not reachable from RUN except as the final step.
- Final step: qout==16'h0001 and tick in RUN:
  - qout -> 0000, state -> DONE.
  - done=1 for exactly the next cycle.
- Ticks in IDLE, PAUSE and DONE are ignored; qout holds. tick coinciding with load/clear is dropped.
- bout = running & tick & (qout[7:0]==8'h00). Marks the edge where the minutes digits decrement.
- running = (state==RUN); expired = (state==DONE).
- DONE holds 00:00 until load, clear or reset.

Optional Feature:
- Macro: BCD_CD_AUTORELOAD_EN.
- Defined:
  - On the final step, qout<=preset instead of 0000 and state stays RUN.
  - done still pulses for 1 cycle; expired is never asserted.
  - If preset==0000, start stays ignored.
- Undefined: behaviour exactly as above, DONE terminal.

Decomposition:
- Package cd_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - digit limit constants (SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9);
  - BCD digit typedef (4 bits).
- Sub-module bcd_digit_dec:
  - One BCD digit down-counter with MAX parameter, enable/borrow_in, borrow_out, sync load.
  - Four instances chained.
- Load sanitization and the FSM stay in the top.

Test Plan:
- Async reset: assert reset=0 mid-RUN at qout=12:34 -> same instant qout=0000, running=0, expired=0; after release, ticks have no effect.
- Load 16'h0103, start, 3 ticks -> qout 0102, 0101, 0100; 4th tick -> 0059 with bout=1 on that edge.
- Load 16'h0002, start, 2 ticks -> 0001, then 0000, state DONE. done high exactly one cycle after that edge; expired stays 1; further ticks and start hold 0000.
- Load 16'hAB7F -> qout=16'h9959 (MIN_TENS_MAX=9). Load 16'h0000 then start -> stays IDLE, running=0.
- From RUN at 0530: pause+start same cycle with tick -> PAUSE, qout holds 0530; start -> RUN; clear -> qout=preset, IDLE; load+clear same cycle -> load value wins.
- With BCD_CD_AUTORELOAD_EN: preset 0002, run 2 ticks -> qout returns to 0002, running stays 1, done pulses once, expired=0.
